// File: rtl/ifd_pkg.sv
// Shared types and constants for the instruction fetch/decode sequencer.
//   ifd_state_t : sequencer states
//   op_t        : 2-bit opcode meanings (unknown encodings never occur, all four are named)
//   *_MSB/*_LSB : instruction field positions
//   HALT_WORD   : instruction word that stops execution when IFD_HALT_OPCODE_EN is defined
package ifd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FETCH,
        ST_ISSUE,
        ST_HALT
    } ifd_state_t;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RD_MSB = 5;
    localparam int RD_LSB = 3;
    localparam int RS_MSB = 2;
    localparam int RS_LSB = 0;

    localparam logic [7:0] HALT_WORD = 8'hFF;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Bus bundle between the fetch/decode sequencer and its surroundings.
//   run                          : start pulse
//   imem_addr / imem_data        : instruction ROM read port
//   init_we/init_waddr/init_wdata: register-file preload write
//   iss_valid/iss_ready/op/rd/rs : decoded instruction handshake to execute stage
//   busy / done                  : status
// master = the sequencer, slave = the environment (ROM, register file, ALU).
interface instr_fetch_decode_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
);
    logic               run;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               init_we;
    logic [2:0]         init_waddr;
    logic [INSTR_W-1:0] init_wdata;
    logic               iss_valid;
    logic               iss_ready;
    logic [1:0]         iss_op;
    logic [2:0]         iss_rd;
    logic [2:0]         iss_rs;
    logic               busy;
    logic               done;

    modport master (
        input  run, imem_data, iss_ready,
        output imem_addr, init_we, init_waddr, init_wdata,
               iss_valid, iss_op, iss_rd, iss_rs, busy, done
    );

    modport slave (
        output run, imem_data, iss_ready,
        input  imem_addr, init_we, init_waddr, init_wdata,
               iss_valid, iss_op, iss_rd, iss_rs, busy, done
    );
endinterface

// File: rtl/ifd_decode.sv
// Combinational instruction slicer: IR -> opcode / rd / rs.
//   ir : instruction word
//   op : opcode field
//   rd : destination (and source A) register
//   rs : source B register
module ifd_decode
    import ifd_pkg::*;
#(
    parameter int INSTR_W = 8
) (
    input  logic [INSTR_W-1:0] ir,
    output op_t                op,
    output logic [2:0]         rd,
    output logic [2:0]         rs
);
    assign op = op_t'(ir[OP_MSB:OP_LSB]);
    assign rd = ir[RD_MSB:RD_LSB];
    assign rs = ir[RS_MSB:RS_LSB];
endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction ROM reader: streams the first NUM_INIT words out as register
// preload writes, then fetches, decodes and issues the remaining words over a
// valid/ready handshake at up to one instruction per cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_decode_if.master (ROM port, preload port, issue
//              handshake, busy/done)
// Optional: define IFD_HALT_OPCODE_EN to make a fetched HALT_WORD stop
// execution instead of being issued.
module instr_fetch_decode
    import ifd_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int INSTR_W  = 8,
    parameter int NUM_INIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_decode_if.master   bus
);
    // Zero preload words skips INIT; a preload covering the whole ROM leaves nothing to run.
    localparam ifd_state_t START_ST  = (NUM_INIT == 0) ? ST_FETCH : ST_INIT;
    localparam ifd_state_t INIT_EXIT = (NUM_INIT == 2**ADDR_W) ? ST_HALT : ST_FETCH;

    ifd_state_t         state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic               last;
    logic               handshake;
    logic               at_last;
    logic               init_end;
    logic               halt_word;
    logic               iss_valid;
    op_t                dec_op;
    logic [2:0]         dec_rd;
    logic [2:0]         dec_rs;

    assign handshake = (state == ST_ISSUE) && bus.iss_ready;
    assign at_last   = &pc;
    assign init_end  = (int'(pc) == NUM_INIT - 1);

`ifdef IFD_HALT_OPCODE_EN
    assign halt_word = (bus.imem_data == INSTR_W'(HALT_WORD));
`else
    assign halt_word = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALT: if (bus.run) state_nxt = START_ST;
            ST_INIT:          if (init_end) state_nxt = INIT_EXIT;
            ST_FETCH:         state_nxt = halt_word ? ST_HALT : ST_ISSUE;
            ST_ISSUE:         if (handshake && (last || halt_word)) state_nxt = ST_HALT;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // pc returns to 0 whenever we stop, so HALT always presents address 0
    // and a restart preloads from the top of the ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= '0;
            last <= 1'b0;
        end else begin
            case (state)
                ST_INIT:  pc <= pc + 1'b1;
                ST_FETCH: begin
                    last <= at_last;
                    pc   <= halt_word ? '0 : pc + 1'b1;
                end
                ST_ISSUE: begin
                    if (handshake) begin
                        if (last || halt_word) begin
                            pc <= '0;
                        end else begin
                            last <= at_last;
                            pc   <= pc + 1'b1;
                        end
                    end
                end
                default:  pc <= '0;
            endcase
        end
    end

    // IR is pure data; the issue outputs are masked by valid so it needs no reset.
    always_ff @(posedge clk) begin
        if ((state == ST_FETCH) || (handshake && !last)) ir <= bus.imem_data;
    end

    ifd_decode #(.INSTR_W(INSTR_W)) u_decode (
        .ir (ir),
        .op (dec_op),
        .rd (dec_rd),
        .rs (dec_rs)
    );

    assign iss_valid      = (state == ST_ISSUE);
    assign bus.imem_addr  = pc;
    assign bus.init_we    = (state == ST_INIT);
    assign bus.init_waddr = bus.init_we ? 3'(pc) : 3'b000;
    assign bus.init_wdata = bus.init_we ? bus.imem_data : '0;
    assign bus.iss_valid  = iss_valid;
    assign bus.iss_op     = iss_valid ? 2'(dec_op) : 2'b00;
    assign bus.iss_rd     = iss_valid ? dec_rd : 3'b000;
    assign bus.iss_rs     = iss_valid ? dec_rs : 3'b000;
    assign bus.busy       = (state == ST_INIT) || (state == ST_FETCH) || (state == ST_ISSUE);
    assign bus.done       = (state == ST_HALT);

endmodule
